// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO types, sizes and Gray/binary helpers
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 4;
  localparam int FIFO_DEPTH     = 1 << FIFO_ADDR_SIZE;

  typedef logic [FIFO_ADDR_SIZE:0] ptr_t;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Operands are zero-extended, so one 32-bit body serves every pointer width up to 32.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/b_to_g.sv
// rtl/b_to_g.sv - combinational binary-to-Gray converter
module b_to_g
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = W'(bin2gray(32'(bin)));

endmodule

// File: rtl/g_to_b.sv
// rtl/g_to_b.sv - combinational Gray-to-binary converter
module g_to_b
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(32'(gray)));

endmodule

// File: rtl/wr_ptr_ctrl.sv
// rtl/wr_ptr_ctrl.sv - async FIFO write-side pointers, level and flags
// WR_OVF_STICKY_EN: overflow held until ovf_clr instead of a per-write pulse.
module wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   wq2_ptr,
  input  logic                 ovf_clr,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 wr_ack,
  output logic                 overflow
);

  localparam int PTR_W = ADDR_SIZE + 1;

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] rbin_s;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ack_q;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             ovf_set;

  b_to_g #(.W(PTR_W)) u_b_to_g (
    .bin  (wbin_d),
    .gray (wgray_d)
  );

  g_to_b #(.W(PTR_W)) u_g_to_b (
    .gray (wq2_ptr),
    .bin  (rbin_s)
  );

  assign push    = wr_en & ~full_q;
  assign ovf_set = wr_en & full_q;
  assign wbin_d  = wbin_q + PTR_W'(push);
  assign level_d = wbin_d - rbin_s;
  // Full when the next write pointer is exactly one lap ahead of the synchronised read pointer.
  assign full_d  = (wgray_d == {~wq2_ptr[ADDR_SIZE:ADDR_SIZE-1], wq2_ptr[ADDR_SIZE-2:0]});
  assign afull_d = (level_d >= PTR_W'(AFULL_THRESH));

`ifdef WR_OVF_STICKY_EN
  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr);
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_d = ovf_set;
`endif

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ack_q   <= push;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr     = wbin_q[ADDR_SIZE-1:0];
  assign wr_ptr_gray = wgray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign wr_ack      = ack_q;
  assign overflow    = ovf_q;

endmodule
